// File: rtl/spsram_req_ctrl.sv
// ---------------------------------------------------------------------------
// spsram_req_ctrl
//
// Request-side controller placed directly in front of a single-port SRAM
// wrapper (default 32768 x 128). Turns a valid/ready request channel (reads
// and byte-strobed writes) into the SRAM pins A/CEN/WEN/D, captures Q one
// cycle after every read into a small response FIFO, and throttles request
// acceptance so read data can never be dropped under response backpressure.
//
// Optional feature macro: SPSRAM_INIT_ZERO_EN
//   When defined, the INIT state sweeps every SRAM word to zero (one word per
//   cycle) before traffic is accepted. When undefined, INIT lasts one cycle
//   and SRAM contents are left untouched.
//
// Ports:
//   CLK        in   clock, all state updates on the rising edge
//   RST        in   synchronous active-high reset
//   req_vld    in   request valid
//   req_rdy    out  request ready (transfer on req_vld && req_rdy)
//   req_wr     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_wstrb  in   byte enables, active-high
//   rsp_vld    out  read data valid
//   rsp_rdy    in   response consumer ready
//   rsp_data   out  read data, in request order
//   A          out  SRAM address
//   CEN        out  SRAM chip enable, active-low
//   WEN        out  SRAM byte write enables, active-low
//   D          out  SRAM write data
//   Q          in   SRAM read data (valid the cycle after a read)
//   init_done  out  controller ready for traffic
// ---------------------------------------------------------------------------
module spsram_req_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 2,
  localparam int BL        = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BL-1:0]         req_wstrb,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic [BL-1:0]         WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q,
  output logic                  init_done
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                    rd_inflight_q, rd_inflight_d;
  logic [ADDR_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   d_q;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [RSP_DEPTH];

  logic                    fire;
  logic                    push;
  logic                    pop;
  logic [CNT_W:0]          occupancy;

`ifdef SPSRAM_INIT_ZERO_EN
  logic [ADDR_WIDTH-1:0]   sweep_addr_q, sweep_addr_d;
  logic                    sweep;
`endif

  // Occupancy counts the read already on its way to the FIFO, so a request
  // is only accepted when its eventual response is guaranteed a slot.
  assign occupancy = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_inflight_q};
  assign req_rdy   = (state_q == ST_RUN) && !RST &&
                     (occupancy < (CNT_W+1)'(RSP_DEPTH));
  assign fire      = req_vld && req_rdy;

  assign init_done = (state_q == ST_RUN) && !RST;
  assign rsp_vld   = (cnt_q != '0) && !RST;
  assign rsp_data  = fifo_mem_q[rd_ptr_q];

  // Q of the read issued last cycle is captured unconditionally.
  assign push = rd_inflight_q;
  assign pop  = rsp_vld && rsp_rdy;

`ifdef SPSRAM_INIT_ZERO_EN
  assign sweep = (state_q == ST_INIT) && !RST;
`endif

  // SRAM pin drive. A and D hold their last driven value when idle.
  always_comb begin
    CEN = 1'b1;
    WEN = '1;
    A   = a_q;
    D   = d_q;
    if (RST) begin
      A = '0;
      D = '0;
`ifdef SPSRAM_INIT_ZERO_EN
    end else if (sweep) begin
      CEN = 1'b0;
      WEN = '0;
      A   = sweep_addr_q;
      D   = '0;
`endif
    end else if (fire) begin
      CEN = 1'b0;
      A   = req_addr;
      D   = req_wdata;
      // A zero-strobe write still selects the SRAM but writes no bytes.
      WEN = req_wr ? ~req_wstrb : '1;
    end
  end

  // Next-state logic for the FSM and FIFO bookkeeping.
  always_comb begin
    state_d       = state_q;
    rd_inflight_d = fire && !req_wr;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
`ifdef SPSRAM_INIT_ZERO_EN
    sweep_addr_d  = sweep_addr_q;
`endif

    case (state_q)
      ST_INIT: begin
`ifdef SPSRAM_INIT_ZERO_EN
        sweep_addr_d = sweep_addr_q + 1'b1;
        if (sweep_addr_q == '1) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // Drops any in-flight read and flushes the FIFO.
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_inflight_q <= 1'b0;
      a_q           <= '0;
      d_q           <= '0;
`ifdef SPSRAM_INIT_ZERO_EN
      sweep_addr_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_inflight_q <= rd_inflight_d;
      a_q           <= A;
      d_q           <= D;
`ifdef SPSRAM_INIT_ZERO_EN
      sweep_addr_q  <= sweep_addr_d;
`endif
    end
  end

  // Response storage; no reset needed since occupancy is tracked by cnt_q.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      fifo_mem_q[wr_ptr_q] <= Q;
    end
  end

  // The acceptance rule should make this unreachable.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && (cnt_q == CNT_W'(RSP_DEPTH))))
        else $error("spsram_req_ctrl: response FIFO push while full");
    end
  end

endmodule

// File: tb/tb_spsram_req_ctrl.sv
// Directed self-checking bench for spsram_req_ctrl (default build).
// Inputs are driven on the falling edge; outputs are checked 1 time unit
// later, i.e. mid-cycle, well away from the rising edge.
module tb_spsram_req_ctrl;

  localparam int AW = 15;
  localparam int DW = 128;
  localparam int BL = DW / 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BL-1:0] req_wstrb = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] A;
  logic          CEN;
  logic [BL-1:0] WEN;
  logic [DW-1:0] D;
  logic [DW-1:0] Q = '0;
  logic          init_done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .A(A), .CEN(CEN), .WEN(WEN), .D(D), .Q(Q),
    .init_done(init_done)
  );

  // Behavioural single-port SRAM: byte writes land at the edge, reads
  // return Q one cycle later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (!CEN) begin
      for (int b = 0; b < BL; b++) begin
        if (!WEN[b]) mem[A][b*8 +: 8] <= D[b*8 +: 8];
      end
      if (&WEN) Q <= mem[A];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic vld, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [BL-1:0] strb);
    req_vld   = vld;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
  endtask

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [DW-1:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] P55  = {16{8'h55}};
  localparam logic [DW-1:0] PMIX = 128'h555555555555555555555555555555AA;

  logic [DW-1:0] exp_d [4];
  int  issued;
  int  got;
  logic f;

  initial begin
    for (int i = 0; i < 4; i++) exp_d[i] = {4{32'hC0DE0000 + 32'(i)}};

    // ---- 1: reset state and INIT length ----
    next_cycle();
    next_cycle();
    #1;
    chk("rst_req_rdy",   DW'(req_rdy),   DW'(0));
    chk("rst_cen",       DW'(CEN),       DW'(1));
    chk("rst_wen",       DW'(WEN),       DW'(16'hFFFF));
    chk("rst_a",         DW'(A),         DW'(0));
    chk("rst_d",         D,              DW'(0));
    chk("rst_init_done", DW'(init_done), DW'(0));
    chk("rst_rsp_vld",   DW'(rsp_vld),   DW'(0));
    next_cycle();
    RST = 1'b0;
    #1;
    chk("init_done_low", DW'(init_done), DW'(0));
    chk("init_rdy_low",  DW'(req_rdy),   DW'(0));
    chk("init_cen",      DW'(CEN),       DW'(1));
    next_cycle();
    #1;
    chk("init_done_high", DW'(init_done), DW'(1));
    chk("run_rdy_high",   DW'(req_rdy),   DW'(1));

    // ---- 2: full write then read-after-write ----
    next_cycle();
    drive(1'b1, 1'b1, 15'h0005, PAT, 16'hFFFF);
    #1;
    chk("wr_cen",  DW'(CEN), DW'(0));
    chk("wr_wen",  DW'(WEN), DW'(0));
    chk("wr_a",    DW'(A),   DW'(15'h0005));
    chk("wr_d",    D,        PAT);
    next_cycle();
    drive(1'b1, 1'b0, 15'h0005, '0, '0);
    rsp_rdy = 1'b1;
    #1;
    chk("rd_cen",  DW'(CEN), DW'(0));
    chk("rd_wen",  DW'(WEN), DW'(16'hFFFF));
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("rd_n1_vld",  DW'(rsp_vld), DW'(0));
    chk("idle_cen",   DW'(CEN),     DW'(1));
    chk("idle_a_hold", DW'(A),      DW'(15'h0005));
    next_cycle();
    #1;
    chk("rd_n2_vld",  DW'(rsp_vld), DW'(1));
    chk("rd_n2_data", rsp_data,     PAT);
    next_cycle();
    #1;
    chk("rd_popped",  DW'(rsp_vld), DW'(0));

    // ---- 3: partial write ----
    next_cycle();
    drive(1'b1, 1'b1, 15'h7FFF, P55, 16'hFFFF);
    next_cycle();
    drive(1'b1, 1'b1, 15'h7FFF, 128'hAA, 16'h0001);
    #1;
    chk("pw_wen", DW'(WEN), DW'(16'hFFFE));
    chk("pw_cen", DW'(CEN), DW'(0));
    next_cycle();
    drive(1'b1, 1'b0, 15'h7FFF, '0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    next_cycle();
    #1;
    chk("pw_vld",  DW'(rsp_vld), DW'(1));
    chk("pw_data", rsp_data,     PMIX);
    next_cycle();

    // ---- zero-strobe write: selects SRAM, no response ----
    drive(1'b1, 1'b1, 15'h0020, PAT, 16'h0000);
    #1;
    chk("zs_cen", DW'(CEN), DW'(0));
    chk("zs_wen", DW'(WEN), DW'(16'hFFFF));
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("zs_rdy", DW'(req_rdy), DW'(1));
    next_cycle();
    #1;
    chk("zs_no_rsp", DW'(rsp_vld), DW'(0));

    // ---- 4: backpressure ----
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b1, 1'b1, AW'(16 + i), exp_d[i], 16'hFFFF);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    rsp_rdy = 1'b0;
    issued = 0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      drive(1'b1, 1'b0, AW'(16 + issued), '0, '0);
      #1;
      if (rsp_vld) chk("bp_hold_data", rsp_data, exp_d[0]);
      f = req_vld && req_rdy;
      @(posedge CLK);
      if (f) issued++;
    end
    #1;
    next_cycle();
    #1;
    chk("bp_issued", DW'(issued),  DW'(2));
    chk("bp_rdy",    DW'(req_rdy), DW'(0));
    chk("bp_vld",    DW'(rsp_vld), DW'(1));
    got = 0;
    rsp_rdy = 1'b1;
    for (int k = 0; k < 30 && got < 4; k++) begin
      drive(issued < 4, 1'b0, AW'(16 + issued), '0, '0);
      #1;
      f = req_vld && req_rdy;
      if (rsp_vld) begin
        chk("bp_order", rsp_data, exp_d[got]);
        got++;
      end
      @(posedge CLK);
      if (f) issued++;
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("bp_total_issued", DW'(issued), DW'(4));
    chk("bp_total_rsp",    DW'(got),    DW'(4));
    next_cycle();
    #1;
    chk("bp_drained", DW'(rsp_vld), DW'(0));

    // ---- 5: reset with one response buffered and one read in flight ----
    next_cycle();
    rsp_rdy = 1'b0;
    drive(1'b1, 1'b0, 15'h0010, '0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 15'h0011, '0, '0);
    #1;
    chk("mr_second_rdy", DW'(req_rdy), DW'(1));
    next_cycle();
    RST = 1'b1;
    drive(1'b1, 1'b0, 15'h0012, '0, '0);
    #1;
    chk("mr_cen", DW'(CEN),     DW'(1));
    chk("mr_rdy", DW'(req_rdy), DW'(0));
    next_cycle();
    RST = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("mr_vld_after",  DW'(rsp_vld),   DW'(0));
    chk("mr_init_low",   DW'(init_done), DW'(0));
    next_cycle();
    rsp_rdy = 1'b1;
    #1;
    chk("mr_init_high",  DW'(init_done), DW'(1));
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      chk("mr_no_stale", DW'(rsp_vld), DW'(0));
    end
    // SRAM contents survive the reset.
    next_cycle();
    drive(1'b1, 1'b0, 15'h0013, '0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    next_cycle();
    #1;
    chk("mr_post_vld",  DW'(rsp_vld), DW'(1));
    chk("mr_post_data", rsp_data,     exp_d[3]);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
